chan_512_buffer_ctrl: RTL and testbench

Capture sequencer for the chan_512 snapshot BRAM. It is commanded by the PPC-written start-buffer register word and aligns each capture to the 512-channel frame sync. It writes a programmed number of words into BRAM, then reports busy/done/abort status and word count back through a status register word. It sits entirely in the user_clk domain, between the software start register and the snapshot BRAM write port.

---
 rtl/chan_512_buffer_ctrl.sv | 141 ++++++++++++++
 tb/tb_chan_512_buffer_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_512_buffer_ctrl.sv
// chan_512 snapshot capture sequencer.
// A rising edge on the start bit arms a capture. The capture begins on the
// first frame sync that carries a valid sample. It writes a latched number of
// words into the snapshot BRAM, and it reports busy/done/aborted/armed plus
// the word count through a status word.
module chan_512_buffer_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       start_reg,
  input  logic              sync_in,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [31:0]       status_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q;
  logic                start_prev_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     count_q;
  logic                done_q;
  logic                aborted_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [31:0]         status_q;

  logic                start_rise;
  logic                abort;
  logic [ADDR_W-1:0]   len_field;
  logic [ADDR_W:0]     len_sel;
  logic [ADDR_W:0]     count_inc;
  logic [31:0]         status_d;
  logic                unused_start_bits;

  assign start_rise = start_reg[0] & ~start_prev_q;
  assign abort      = start_reg[1];
  assign len_field  = start_reg[16 +: ADDR_W];
  // A zero length field selects the full BRAM depth.
  assign len_sel    = (len_field == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_field};
  assign count_inc  = count_q + 1'b1;
  assign unused_start_bits = ^{start_reg[15:2], start_reg[31:16+ADDR_W]};

  // Assemble the status word from the current flags and count; it is registered below.
  always_comb begin
    status_d                  = '0;
    status_d[0]               = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    status_d[1]               = done_q;
    status_d[2]               = aborted_q;
    status_d[3]               = (state_q == S_ARMED);
    status_d[16 +: ADDR_W+1]  = count_q;
  end

  // Capture sequencer with registered BRAM write port and status word.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      len_q        <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      status_q     <= '0;
    end else begin
      start_prev_q <= start_reg[0];
      status_q     <= status_d;
      we_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_rise && !abort) begin
            state_q   <= S_ARMED;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            count_q   <= '0;
            len_q     <= len_sel;
          end
        end
        S_ARMED: begin
          if (abort) begin
            state_q   <= S_IDLE;
            aborted_q <= 1'b1;
          end else if (sync_in && din_valid) begin
            we_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= din;
            count_q <= {{ADDR_W{1'b0}}, 1'b1};
            if (len_q == {{ADDR_W{1'b0}}, 1'b1}) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            state_q   <= S_IDLE;
            aborted_q <= 1'b1;
          end else if (din_valid) begin
            we_q    <= 1'b1;
            addr_q  <= count_q[ADDR_W-1:0];
            wdata_q <= din;
            count_q <= count_inc;
            if (count_inc == len_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Wait for start to drop, so that a new capture requires a fresh rising edge.
          if (!start_reg[0]) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_din   = wdata_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_chan_512_buffer_ctrl.sv
// Self-checking bench for chan_512_buffer_ctrl: per-cycle write checks against
// a transaction-level capture model, plus status checks at settled points.
module tb_chan_512_buffer_ctrl;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              user_clk = 1'b0;
  logic              user_rst_n = 1'b0;
  logic [31:0]       start_reg = '0;
  logic              sync_in = 1'b0;
  logic              din_valid = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [31:0]       status_out;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] len_field = '0;

  // Reference model: capture session bookkeeping in plain terms.
  bit m_prev_st;       // last start bit seen
  bit m_session;       // a capture is armed or running
  bit m_seen_sync;     // the qualifying sync has arrived
  bit m_wait_release;  // capture finished; waiting for start to drop
  bit m_done;
  bit m_aborted;
  int m_written;
  int m_len;

  chan_512_buffer_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .start_reg  (start_reg),
    .sync_in    (sync_in),
    .din_valid  (din_valid),
    .din        (din),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .status_out (status_out)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_prev_st = 0; m_session = 0; m_seen_sync = 0; m_wait_release = 0;
    m_done = 0; m_aborted = 0; m_written = 0; m_len = 0;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    logic [11:0] cnt;
    s = '0;
    cnt = m_written[11:0];
    s[0] = m_session;
    s[1] = m_done;
    s[2] = m_aborted;
    s[3] = m_session && !m_seen_sync;
    s[27:16] = cnt;
    return s;
  endfunction

  // One clock cycle: apply inputs, advance the model, and check the write port.
  task automatic cyc(input bit st, input bit ab, input bit sy, input bit va, input logic [31:0] d);
    bit exp_we;
    int exp_addr;
    logic [31:0] exp_din;
    bit rise;
    start_reg = {5'b0, len_field, 14'b0, ab, st};
    sync_in = sy;
    din_valid = va;
    din = d;
    @(posedge user_clk);
    #1;
    exp_we = 0; exp_addr = 0; exp_din = '0;
    rise = st && !m_prev_st;
    if (m_wait_release) begin
      if (!st) m_wait_release = 0;
    end else if (m_session) begin
      if (ab) begin
        m_session = 0;
        m_aborted = 1;
      end else if (va && (m_seen_sync || sy)) begin
        m_seen_sync = 1;
        exp_we = 1;
        exp_addr = m_written;
        exp_din = d;
        m_written++;
        if (m_written == m_len) begin
          m_session = 0;
          m_done = 1;
          m_wait_release = 1;
        end
      end
    end else if (rise && !ab) begin
      m_session = 1; m_seen_sync = 0; m_written = 0; m_done = 0; m_aborted = 0;
      m_len = (len_field == 0) ? DEPTH : int'(len_field);
    end
    m_prev_st = st;

    checks++;
    if (bram_we !== exp_we) begin
      failures++;
      $display("FAIL bram_we t=%0t got=%b expected=%b", $time, bram_we, exp_we);
    end else if (exp_we) begin
      checks++;
      if (bram_addr !== exp_addr[ADDR_W-1:0] || bram_din !== exp_din) begin
        failures++;
        $display("FAIL write t=%0t addr got=%h expected=%h data got=%h expected=%h",
                 $time, bram_addr, exp_addr[ADDR_W-1:0], bram_din, exp_din);
      end
    end
  endtask

  // Hold inputs quiet for one cycle so the registered status settles, then compare.
  task automatic check_status(input string name);
    logic [31:0] exp;
    cyc(m_prev_st, 0, 0, 0, '0);
    exp = model_status();
    checks++;
    if (status_out !== exp) begin
      failures++;
      $display("FAIL status_%s got=%h expected=%h", name, status_out, exp);
    end
  endtask

  task automatic arm(input logic [ADDR_W-1:0] lf);
    len_field = lf;
    cyc(0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if (bram_we !== 1'b0 || bram_addr !== '0 || bram_din !== '0 || status_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs we=%b addr=%h din=%h status=%h expected all zero",
               bram_we, bram_addr, bram_din, status_out);
    end
    repeat (3) @(posedge user_clk);
    #1 user_rst_n = 1'b1;
    check_status("after_reset");
  endtask

  task automatic test_len8();
    arm(11'd8);
    check_status("len8_armed");
    cyc(1, 0, 0, 1, 32'h11);      // valid without sync: ignored
    for (int i = 0; i < 8; i++) cyc(1, 0, (i == 0), 1, 32'hA0 + i);
    repeat (3) cyc(1, 0, 1, 1, 32'hBB);
    check_status("len8_done");
  endtask

  task automatic test_full_depth();
    arm(11'd0);
    cyc(1, 0, 1, 1, $urandom);
    for (int i = 1; i < DEPTH + 3; i++) cyc(1, 0, 0, 1, $urandom);
    check_status("full_depth");
    checks++;
    if (status_out[27] !== 1'b1) begin
      failures++;
      $display("FAIL full_depth_bit27 got=%b expected=1", status_out[27]);
    end
  endtask

  task automatic test_sync_qualify();
    arm(11'd12);
    cyc(1, 0, 1, 0, 32'h55);
    repeat (4) cyc(1, 0, 0, 0, '0);
    check_status("sync_still_armed");
    cyc(1, 0, 1, 1, 32'hC0);
    for (int i = 1; i < 14; i++) begin
      cyc(1, 0, 0, 1, 32'hC0 + i);
      repeat (3) cyc(1, 0, ($urandom % 2 == 0), 0, $urandom);
    end
    check_status("sync_gaps_done");
  endtask

  task automatic test_abort();
    arm(11'd16);
    cyc(1, 0, 1, 1, 32'hD0);
    for (int i = 1; i < 5; i++) cyc(1, 0, 0, 1, 32'hD0 + i);
    cyc(1, 1, 0, 1, 32'hDEAD);
    check_status("aborted");
    repeat (5) cyc(1, 0, 1, 1, 32'hEE);
    check_status("abort_no_rearm");
    cyc(0, 0, 0, 0, '0);
    cyc(1, 1, 0, 0, '0);           // abort blocks arming in idle
    check_status("abort_blocks_arm");
    cyc(0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    check_status("rearm_after_abort");
    cyc(1, 1, 0, 0, '0);
  endtask

  task automatic test_done_hold();
    arm(11'd4);
    cyc(1, 0, 1, 1, 32'hF0);
    for (int i = 1; i < 4; i++) cyc(1, 0, 0, 1, 32'hF0 + i);
    repeat (3) cyc(1, 1, 1, 1, 32'h99);   // abort ignored in done
    check_status("done_held");
    cyc(0, 0, 0, 0, '0);
    check_status("done_released");
    cyc(1, 0, 0, 0, '0);
    check_status("done_rearmed");
    cyc(1, 1, 0, 0, '0);
  endtask

  task automatic test_reset_mid_capture();
    arm(11'd64);
    cyc(1, 0, 1, 1, $urandom);
    for (int i = 1; i < 37; i++) cyc(1, 0, 0, 1, $urandom);
    check_status("pre_reset_count37");
    user_rst_n = 1'b0;
    #1;
    checks++;
    if (bram_we !== 1'b0 || status_out !== '0) begin
      failures++;
      $display("FAIL async_reset we=%b status=%h expected we=0 status=0", bram_we, status_out);
    end
    start_reg = '0; sync_in = 0; din_valid = 0;
    model_reset();
    @(posedge user_clk);
    #1 user_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(0, 0, ($urandom % 2 == 0), 1, $urandom);
    check_status("post_reset_idle");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      arm((r == 0) ? 11'd1 : 11'($urandom_range(2, 40)));
      for (int i = 0; i < 120; i++)
        cyc(($urandom % 16 != 0), ($urandom % 50 == 0), ($urandom % 6 == 0),
            ($urandom % 4 != 0), $urandom);
      check_status("random_round");
      cyc(1, 1, 0, 0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_len8();
    test_full_depth();
    test_sync_qualify();
    test_abort();
    test_done_hold();
    test_reset_mid_capture();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
